// File: rtl/sync_fifo_ctrl_pkg.sv
//------------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the single-clock FIFO controller (sync_fifo_ctrl)
//   and its storage array (sync_fifo_ram).
//   - DEFAULT_ADDR_WIDTH / DEPTH : default geometry (8 entries)
//   - flags_t / FLAGS_RESET      : registered status flags and their idle value
//   - depth_of()                 : depth from address width
//   - next_flags()               : status flags from an occupancy value
//------------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 3;
  localparam int unsigned DEPTH              = 32'd1 << DEFAULT_ADDR_WIDTH;

  typedef struct packed {
    logic wfull;
    logic rempty;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  // Flag values for an empty FIFO; used both on reset and on flush.
  localparam flags_t FLAGS_RESET = '{wfull: 1'b0, rempty: 1'b1,
                                     almost_full: 1'b0, almost_empty: 1'b1};

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // All four flags are pure functions of occupancy, so the controller feeds
  // this with the next-state count and registers the result alongside it.
  function automatic flags_t next_flags(input int unsigned cnt,
                                        input int unsigned depth,
                                        input int unsigned af_margin,
                                        input int unsigned ae_margin);
    flags_t f;
    f.wfull        = (cnt == depth);
    f.rempty       = (cnt == 0);
    f.almost_full  = (cnt >= depth - af_margin);
    f.almost_empty = (cnt <= ae_margin);
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
//------------------------------------------------------------------------------
// sync_fifo_ram
//   Register array with one synchronous write port and one read address.
//   REG_READ=1 : o_rdata is a register loaded from mem[i_raddr] when i_re is
//                high, cleared by reset, held otherwise.
//   REG_READ=0 : o_rdata = mem[i_raddr] combinationally (i_re, rst_n unused).
//
//   clk, rst_n     clock, async active-low reset (read register only)
//   i_we, i_waddr, i_wdata   write port
//   i_re, i_raddr  read enable / read address
//   o_rdata        read data
//------------------------------------------------------------------------------
module sync_fifo_ram #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          REG_READ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset branch on purpose; resetting every entry
  // would turn it into a flop bank with reset muxes and nothing reads a slot
  // before it has been written.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  generate
    if (REG_READ) begin : g_reg_read
      logic [DATA_WIDTH-1:0] r_rdata;

      // NOTE: sequential state is always assigned with <= so every flop
      // samples the pre-edge values regardless of block ordering.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rdata <= '0;
        end else if (i_re) begin
          r_rdata <= r_mem[i_raddr];
        end
      end

      assign o_rdata = r_rdata;
    end else begin : g_comb_read
      // First-word-fall-through: the head entry is always on the output.
      assign o_rdata = r_mem[i_raddr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_ctrl.sv
//------------------------------------------------------------------------------
// sync_fifo_ctrl
//   Parametrised single-clock FIFO with occupancy count, almost-full /
//   almost-empty thresholds, sticky overflow/underflow flags and a
//   synchronous flush. Pointers are plain binary (ADDR_WIDTH+1 bits, MSB
//   toggles on wrap); no synchronisers are needed.
//
//   Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through
//   (rdata combinational from the array head); otherwise rdata is registered
//   and updates on the edge that accepts a read.
//
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     winc, wdata           write request / data
//     rinc                  read request
//     flush                 synchronous flush (empties FIFO, keeps errors)
//     clr_err               clear sticky error flags
//     rdata                 read data
//     wfull, rempty         full / empty
//     almost_full/_empty    threshold flags
//     count                 occupancy 0..DEPTH
//     overflow, underflow   sticky error flags
//------------------------------------------------------------------------------
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_MARGIN  = 2,
  parameter int unsigned AE_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned FIFO_DEPTH = depth_of(ADDR_WIDTH);

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit REG_READ = 1'b0;
`else
  localparam bit REG_READ = 1'b1;
`endif

  typedef logic [ADDR_WIDTH:0] ptr_t;

  ptr_t   r_wptr;
  ptr_t   r_rptr;
  ptr_t   r_count;
  flags_t r_flags;
  logic   r_overflow;
  logic   r_underflow;

  logic   w_wr_acc;
  logic   w_rd_acc;
  ptr_t   w_wptr_nxt;
  ptr_t   w_rptr_nxt;
  ptr_t   w_count_nxt;
  flags_t w_flags_nxt;

  // Acceptance looks only at the registered flags, so a simultaneous
  // read+write on a full FIFO drops the write and on an empty FIFO drops the
  // read. Flush suppresses both.
  assign w_wr_acc = winc && !r_flags.wfull  && !flush;
  assign w_rd_acc = rinc && !r_flags.rempty && !flush;

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (flush) begin
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      if (w_wr_acc) w_wptr_nxt = r_wptr + ptr_t'(1);
      if (w_rd_acc) w_rptr_nxt = r_rptr + ptr_t'(1);
      w_count_nxt = r_count + ptr_t'(w_wr_acc) - ptr_t'(w_rd_acc);
    end
    // A zero count yields FLAGS_RESET, so flush needs no special case here.
    w_flags_nxt = next_flags(32'(w_count_nxt), FIFO_DEPTH, AF_MARGIN, AE_MARGIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_flags <= FLAGS_RESET;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  // Sticky errors: a set beats a same-cycle clear; flush leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!flush) begin
      if (winc && r_flags.wfull) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (rinc && r_flags.rempty) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  sync_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_READ   (REG_READ)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (wdata),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (rdata)
  );

  assign wfull        = r_flags.wfull;
  assign rempty       = r_flags.rempty;
  assign almost_full  = r_flags.almost_full;
  assign almost_empty = r_flags.almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
//------------------------------------------------------------------------------
// tb_sync_fifo_ctrl
//   Self-checking bench for sync_fifo_ctrl (ADDR_WIDTH=3, DATA_WIDTH=8,
//   AF_MARGIN=2, AE_MARGIN=2). A queue-based model tracks contents, read data
//   and sticky errors; a negedge process compares every output against it.
//   Directed scenarios add literal expectations, then random traffic follows.
//------------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AF    = 2;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       winc = 1'b0;
  logic [7:0] wdata = '0;
  logic       rinc = 1'b0;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rdata;
  logic       wfull, rempty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  sync_fifo_ctrl #(
    .ADDR_WIDTH (3),
    .DATA_WIDTH (8),
    .AF_MARGIN  (AF),
    .AE_MARGIN  (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wdata        (wdata),
    .rinc         (rinc),
    .flush        (flush),
    .clr_err      (clr_err),
    .rdata        (rdata),
    .wfull        (wfull),
    .rempty       (rempty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model
  logic [7:0] q[$];
  logic [7:0] m_rdata = '0;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal read-data expectations only apply to the registered-read build.
  task automatic check_rd(input string name, input logic [7:0] exp);
`ifndef SYNC_FIFO_FWFT_EN
    check(name, rdata, exp);
`else
    if (!rempty) check(name, rdata, q[0]);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic model_edge(input bit w, input logic [7:0] d, input bit r,
                            input bit f, input bit c);
    int sz;
    sz = q.size();
    if (f) begin
      q.delete();
    end else begin
      if (r && sz != 0) m_rdata = q.pop_front();
      if (w && sz != DEPTH) q.push_back(d);
      if (w && sz == DEPTH) m_ovf = 1'b1;
      else if (c)           m_ovf = 1'b0;
      if (r && sz == 0)     m_udf = 1'b1;
      else if (c)           m_udf = 1'b0;
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model.
  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit f = 1'b0, input bit c = 1'b0);
    winc = w; wdata = d; rinc = r; flush = f; clr_err = c;
    @(posedge clk);
    model_edge(w, d, r, f, c);
    #1;
    winc = 1'b0; rinc = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("count",        count,        q.size());
      check("wfull",        wfull,        q.size() == DEPTH);
      check("rempty",       rempty,       q.size() == 0);
      check("almost_full",  almost_full,  q.size() >= DEPTH - AF);
      check("almost_empty", almost_empty, q.size() <= AE);
      check("overflow",     overflow,     m_ovf);
      check("underflow",    underflow,    m_udf);
`ifndef SYNC_FIFO_FWFT_EN
      check("rdata",        rdata,        m_rdata);
`else
      if (q.size() != 0) check("rdata_fwft", rdata, q[0]);
`endif
    end
  end

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);

    // 1: async reset mid-traffic at count=5 with underflow set
    step(0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(1, 8'h20 + 8'(i), 0);
    check("t1_count5", count, 5);
    check("t1_udf_set", underflow, 1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_count",  count, 0);
    check("t1_rst_rempty", rempty, 1);
    check("t1_rst_wfull",  wfull, 0);
    check("t1_rst_af",     almost_full, 0);
    check("t1_rst_ae",     almost_empty, 1);
    check("t1_rst_udf",    underflow, 0);
    check("t1_rst_ovf",    overflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("t1_rst_rdata",  rdata, 0);
`endif
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(1, 8'h3C, 0);
    step(0, 8'h00, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("t1_rd_after_rst", rdata, 8'h3C);
`endif

    // 2: fill 0x10..0x17, overflow, drain
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'h0F + 8'(i), 0);
      check("t2_count", count, i);
      check("t2_af",    almost_full,  i >= 6);
      check("t2_ae",    almost_empty, i <= 2);
      check("t2_wfull", wfull,        i == 8);
    end
    step(1, 8'hFF, 0);
    check("t2_ovf", overflow, 1);
    check("t2_count_full", count, 8);
    for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("t2_fwft_head", rdata, 8'h10 + 8'(i));
`endif
      step(0, 8'h00, 1);
`ifndef SYNC_FIFO_FWFT_EN
      check("t2_rdata", rdata, 8'h10 + 8'(i));
`endif
    end
    check("t2_rempty", rempty, 1);

    // 3: simultaneous read/write at full and mid-level
    for (int i = 0; i < 8; i++) step(1, 8'h40 + 8'(i), 0);
    step(1, 8'hEE, 1);
    check("t3_count7", count, 7);
    check("t3_wfull0", wfull, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
    check("t3_count4", count, 4);
    step(1, 8'h77, 1);
    check("t3_count_hold", count, 4);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
    check_rd("t3_last", 8'h77);

    // 4: steady-state streaming at count=1, pointers wrap twice
    step(1, 8'hA0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'hA1 + 8'(i), 1);
`ifndef SYNC_FIFO_FWFT_EN
      check("t4_rdata", rdata, 8'hA0 + 8'(i));
`endif
      check("t4_count", count, 1);
    end
    step(0, 8'h00, 1);

    // 5: flush with a concurrent write
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0);
    step(1, 8'hAA, 0, 1);
    check("t5_count", count, 0);
    check("t5_rempty", rempty, 1);
    check("t5_ae", almost_empty, 1);
    check("t5_ovf", overflow, 0);
    step(1, 8'h55, 0);
    step(0, 8'h00, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("t5_rdata", rdata, 8'h55);
`endif

    // 6: underflow set / clear / set-wins
    step(0, 8'h00, 1);
    check("t6_udf", underflow, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("t6_rdata_hold", rdata, 8'h55);
`endif
    step(0, 8'h00, 0, 0, 1);
    check("t6_udf_clr", underflow, 0);
    step(0, 8'h00, 1, 0, 1);
    check("t6_udf_setwins", underflow, 1);

    // Random traffic in write-biased, read-biased and balanced phases
    for (int ph = 0; ph < 6; ph++) begin
      int wp;
      int rp;
      wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      rp = 100 - wp;
      for (int n = 0; n < 250; n++) begin
        step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
             $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4);
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO. Successor to the dual-clock FIFO for paths where producer and consumer share one clock domain. Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. Needs no pointer synchronisers; pointers are binary.

Parameters:
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (min 1)
DATA_WIDTH, 8, data word width
AF_MARGIN, 2, almost_full when count >= DEPTH - AF_MARGIN (0 < AF_MARGIN < DEPTH)
AE_MARGIN, 2, almost_empty when count <= AE_MARGIN (0 <= AE_MARGIN < DEPTH)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
winc  in  1  write request
wdata  in  DATA_WIDTH  write data
rinc  in  1  read request
flush  in  1  synchronous flush, single-cycle pulse
clr_err  in  1  clears sticky error flags
rdata  out  DATA_WIDTH  read data
wfull  out  1  FIFO full
rempty  out  1  FIFO empty
almost_full  out  1  threshold flag
almost_empty  out  1  threshold flag
count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async on rst_n low, released on a clk edge): rdata=0, wfull=0, rempty=1, almost_full=0, almost_empty=1, count=0, overflow=0, underflow=0, pointers=0. Memory contents are not reset.
- Pointers: ADDR_WIDTH+1-bit binary. Address = low ADDR_WIDTH bits. MSB toggles on wrap.
- Write accepted iff winc && !wfull. Stores wdata at waddr and increments wptr.
- Read accepted iff rinc && !rempty. Increments rptr.
- Acceptance uses the registered flags. Simultaneous winc+rinc:
  - when full: read accepted, write rejected; count goes to DEPTH-1.
  - when empty: write accepted, read rejected; count goes to 1.
  - otherwise: both accepted; count unchanged.
- count, wfull (count==DEPTH), rempty (count==0), almost_full and almost_empty are all registered. They are computed from next-state count, so all update on the same edge as the accepted operation.
- rdata (default mode): registered. Loads mem[raddr] on the edge that accepts a read, so the word is visible 1 cycle after the rinc edge. rdata holds its value otherwise, including when the FIFO is empty.
- overflow: set on any edge with winc && wfull. underflow: set on any edge with rinc && rempty. clr_err clears both; a set in the same cycle wins over the clear.
- flush: on that edge, pointers and count go to 0 and flags take their reset values. flush overrides winc/rinc in the same cycle; the word is dropped and no error is flagged. rdata and the error flags are unchanged.
- Rejected operations never modify memory, pointers or rdata.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined: first-word-fall-through mode. rdata = mem[raddr], driven combinationally from the register array, and is valid whenever rempty=0. A write into an empty FIFO makes the word visible on rdata at the same edge rempty falls. rinc consumes the displayed word. rdata is undefined-but-stable (last array entry addressed) while empty.
- Undefined: registered-read behaviour as above.

Decomposition:
- Package fifo_pkg: function clog2-free depth constant helper, typedef ptr_t (logic [ADDR_WIDTH:0] via parameterised usage in module), enum-free. Also holds the localparams DEPTH and the flag-threshold computation function next_flags().
- One sub-module: sync_fifo_ram. Write-synchronous register array with one write port and one read address. It has a registered or combinational read selected by a parameter driven from the macro.

Test Plan:
1. Reset asserted mid-traffic at count=5 -> all outputs reach reset values immediately (async), without waiting for clk; after release, one write then read returns new data.
2. Test configuration for scenarios 2-6: ADDR_WIDTH=3, DATA_WIDTH=8, AF=2, AE=2. Write 0x10..0x17 on 8 consecutive edges:
   - almost_full=1 after the 6th write; almost_empty=0 after the 3rd; wfull=1 and count=8 after the 8th.
   - A 9th write of 0xFF -> overflow=1, count stays 8.
   - Then 8 reads -> 0x10..0x17 in order (1-cycle latency); rempty=1 after the 8th.
3. At full, winc+rinc for one cycle -> read accepted, count=7, wfull=0; at count=4, winc+rinc -> count stays 4 and order is preserved.
4. Interleave 20 writes/reads, keeping count between 1 and 3, so pointers wrap twice -> rdata sequence matches write sequence exactly; wfull never asserts.
5. At count=5, flush with winc=1 and wdata=0xAA in the same cycle -> count=0, rempty=1, almost_empty=1, no overflow. Write 0x55 and read -> rdata=0x55.
6. Empty FIFO, rinc -> underflow=1, rdata unchanged. clr_err alone -> underflow=0. clr_err together with rinc on empty -> underflow stays 1.
